// File: rtl/wb_lsu_master_pkg.sv
// Shared definitions for the Wishbone load/store master: size codes, lane-select
// encodings, FSM states and small decode helpers.
package wb_lsu_master_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_TAG  = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_CHECK,
        ST_FAULT
    } lsu_state_e;

    // The RAM decodes the operation from wb_sel; 0101 marks a tag access.
    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;
    localparam logic [3:0] WB_SEL_TAG  = 4'b0101;

    function automatic logic [3:0] sel_for_size(input lsu_size_e size);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = WB_SEL_BYTE;
            SZ_HALF: sel = WB_SEL_HALF;
            SZ_WORD: sel = WB_SEL_WORD;
            default: sel = WB_SEL_TAG;
        endcase
        return sel;
    endfunction

    // Tag ops address a whole granule, so they can never be misaligned.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/wb_lsu_master_if.sv
// Core request/response and Wishbone/tag-RAM signal bundle for wb_lsu_master.
// master = the LSU view; slave = the core + RAM side.
interface wb_lsu_master_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4
) ();

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [1:0]               req_size_i;
    logic                     req_unsigned_i;
    logic                     req_check_i;
    logic [WB_ADDR_WIDTH-1:0] req_addr_i;
    logic [WB_DATA_WIDTH-1:0] req_data_i;

    logic                     resp_valid_o;
    logic [WB_DATA_WIDTH-1:0] resp_data_o;
    logic                     resp_misalign_o;
    logic                     resp_buserr_o;
    logic                     resp_tagfault_o;

    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [WB_DATA_WIDTH-1:0] wb_data_o;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
    logic                     wb_we_o;
    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic [WB_DATA_WIDTH-1:0] wb_data_i;
    logic                     wb_ack_i;

    logic                     check_tags_o;
    logic                     tag_mismatch_i;
    logic                     clear_mismatch_o;

    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_check_i,
               req_addr_i, req_data_i, wb_data_i, wb_ack_i, tag_mismatch_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_misalign_o, resp_buserr_o,
               resp_tagfault_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o,
               wb_stb_o, check_tags_o, clear_mismatch_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_check_i,
               req_addr_i, req_data_i, wb_data_i, wb_ack_i, tag_mismatch_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_misalign_o, resp_buserr_o,
               resp_tagfault_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o,
               wb_stb_o, check_tags_o, clear_mismatch_o
    );

endinterface

// File: rtl/wb_lsu_extend.sv
// Load-data extension: right-justified RAM data widened to the full register
// width by sign or zero extension; word and tag results pass through.
module wb_lsu_extend
    import wb_lsu_master_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32
) (
    input  logic [WB_DATA_WIDTH-1:0] i_data,
    input  lsu_size_e                i_size,
    input  logic                     i_unsigned,
    output logic [WB_DATA_WIDTH-1:0] o_data
);

    logic w_byte_fill;
    logic w_half_fill;

    assign w_byte_fill = !i_unsigned && i_data[7];
    assign w_half_fill = !i_unsigned && i_data[15];

    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_BYTE: o_data = {{(WB_DATA_WIDTH-8){w_byte_fill}}, i_data[7:0]};
            SZ_HALF: o_data = {{(WB_DATA_WIDTH-16){w_half_fill}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding load/store master in front of the tagged Wishbone RAM:
// one classic cycle per request, with misalign, timeout and tag-fault reporting.
module wb_lsu_master
    import wb_lsu_master_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_lsu_master_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e               r_state;
    lsu_state_e               w_next;
    logic                     r_we;
    lsu_size_e                r_size;
    logic                     r_unsigned;
    logic                     r_check;
    logic [WB_ADDR_WIDTH-1:0] r_addr;
    logic [WB_DATA_WIDTH-1:0] r_wdata;
    logic [WB_DATA_WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0]         r_cnt;

    lsu_size_e                w_req_size;
    logic                     w_accept;
    logic                     w_timeout;
    logic [WB_DATA_WIDTH-1:0] w_ext;

    assign w_req_size = lsu_size_e'(bus.req_size_i);
    assign w_accept   = (r_state == ST_IDLE) && bus.req_valid_i;
    // An ack arriving in the last allowed cycle still completes the access.
    assign w_timeout  = (r_cnt == CNT_LAST) && !bus.wb_ack_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_check    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we_i;
                r_size     <= w_req_size;
                r_unsigned <= bus.req_unsigned_i;
                r_check    <= bus.req_check_i && (w_req_size != SZ_TAG);
                r_addr     <= bus.req_addr_i;
                r_wdata    <= bus.req_data_i;
            end
            if ((r_state == ST_BUS) && bus.wb_ack_i) begin
                r_rdata <= bus.wb_data_i;
            end
            r_cnt <= (r_state == ST_BUS) ? r_cnt + 1'b1 : '0;
        end
    end

    wb_lsu_extend #(
        .WB_DATA_WIDTH(WB_DATA_WIDTH)
    ) u_extend (
        .i_data    (r_rdata),
        .i_size    (r_size),
        .i_unsigned(r_unsigned),
        .o_data    (w_ext)
    );

    always_comb begin
        w_next               = r_state;
        bus.req_ready_o      = 1'b0;
        bus.resp_valid_o     = 1'b0;
        bus.resp_data_o      = '0;
        bus.resp_misalign_o  = 1'b0;
        bus.resp_buserr_o    = 1'b0;
        bus.resp_tagfault_o  = 1'b0;
        bus.wb_addr_o        = '0;
        bus.wb_data_o        = '0;
        bus.wb_sel_o         = '0;
        bus.wb_we_o          = 1'b0;
        bus.wb_cyc_o         = 1'b0;
        bus.wb_stb_o         = 1'b0;
        bus.check_tags_o     = 1'b0;
        bus.clear_mismatch_o = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    w_next = is_misaligned(w_req_size, bus.req_addr_i[1:0]) ? ST_FAULT : ST_BUS;
                end
            end
            ST_FAULT: begin
                bus.resp_valid_o    = 1'b1;
                bus.resp_misalign_o = 1'b1;
                w_next              = ST_IDLE;
            end
            ST_BUS: begin
                bus.wb_addr_o = r_addr;
                bus.wb_data_o = r_wdata;
                bus.wb_sel_o  = sel_for_size(r_size);
                bus.wb_we_o   = r_we;
                if (w_timeout) begin
                    bus.resp_valid_o  = 1'b1;
                    bus.resp_buserr_o = 1'b1;
                    w_next            = ST_IDLE;
                end else begin
                    // cyc/stb held through the ack cycle: the RAM samples the tag then.
                    bus.wb_cyc_o     = 1'b1;
                    bus.wb_stb_o     = 1'b1;
                    bus.check_tags_o = r_check;
                    if (bus.wb_ack_i) begin
                        w_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                bus.resp_valid_o     = 1'b1;
                bus.resp_tagfault_o  = bus.tag_mismatch_i && r_check;
                bus.clear_mismatch_o = 1'b1;
                if (!r_we && !(bus.tag_mismatch_i && r_check)) begin
                    bus.resp_data_o = w_ext;
                end
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Bench for wb_lsu_master: behavioural tagged RAM slave, byte-level reference
// model, directed vector table, hand-written corner sequences and random traffic.
module tb_wb_lsu_master;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_lsu_master_if bus ();

    wb_lsu_master #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .WB_SEL_WIDTH  (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    // ---------------- tagged RAM slave model ----------------
    logic [31:0] ram     [0:1023] = '{default: '0};
    logic [3:0]  ram_tag [0:255]  = '{default: '0};
    logic        ram_ack, ram_mis, ram_noack, stale_mis;
    logic [31:0] ram_rd;
    int          ram_wait, ram_need;
    logic [9:0]  ram_widx;
    logic [1:0]  ram_lane;
    logic [7:0]  ram_gran;

    assign ram_widx = bus.wb_addr_o[11:2];
    assign ram_lane = bus.wb_addr_o[1:0];
    assign ram_gran = bus.wb_addr_o[11:4];
    always_comb ram_need = (bus.wb_we_o && (bus.wb_sel_o == 4'b0001 || bus.wb_sel_o == 4'b0011)) ? 2 : 1;

    assign bus.wb_ack_i       = ram_ack;
    assign bus.wb_data_i      = ram_rd;
    assign bus.tag_mismatch_i = ram_mis | stale_mis;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ack  <= 1'b0;
            ram_mis  <= 1'b0;
            ram_wait <= 0;
            ram_rd   <= '0;
        end else begin
            if (bus.clear_mismatch_o) ram_mis <= 1'b0;
            if (!(bus.wb_cyc_o && bus.wb_stb_o) || ram_ack) begin
                ram_ack  <= 1'b0;
                ram_wait <= 0;
            end else if (!ram_noack && ram_wait == ram_need - 1) begin
                ram_ack <= 1'b1;
                if (bus.check_tags_o && bus.wb_addr_o[31:28] != ram_tag[ram_gran]) ram_mis <= 1'b1;
                if (bus.wb_sel_o == 4'b0101) begin
                    if (bus.wb_we_o) ram_tag[ram_gran] <= bus.wb_data_o[3:0];
                    else ram_rd <= {28'h0, ram_tag[ram_gran]};
                end else if (bus.wb_we_o) begin
                    case (bus.wb_sel_o)
                        4'b0001: ram[ram_widx][{ram_lane, 3'b000} +: 8]    <= bus.wb_data_o[7:0];
                        4'b0011: ram[ram_widx][{ram_lane[1], 4'b0000} +: 16] <= bus.wb_data_o[15:0];
                        default: ram[ram_widx] <= bus.wb_data_o;
                    endcase
                end else begin
                    ram_rd <= ram[ram_widx] >> {ram_lane, 3'b000};
                end
            end else begin
                ram_wait <= ram_wait + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic        chk;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        req_t        rq;
        logic [31:0] d;
        logic        mis;
        logic        tf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        mis, be, tf;
        int          lat, cyc, clr;
        logic [3:0]  sel;
        logic [31:0] addr, wdata;
        logic        we, chk, rdy_bad;
    } obs_t;

    logic [7:0] ref_mem [0:4095] = '{default: '0};
    logic [3:0] ref_tag [0:255]  = '{default: '0};

    task automatic ref_apply(input req_t rq, output logic [31:0] d, output logic mis,
                             output logic tf, output int lat);
        logic [11:0] a;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] h;
        a   = rq.addr[11:0];
        g   = a[11:4];
        d   = '0;
        tf  = 1'b0;
        mis = (rq.size == 2'd1 && a[0]) || (rq.size == 2'd2 && a[1:0] != 2'b00);
        if (mis) begin
            lat = 1;
            return;
        end
        tf = rq.chk && rq.size != 2'd3 && rq.addr[31:28] != ref_tag[g];
        if (rq.we) begin
            lat = (rq.size < 2'd2) ? 4 : 3;
            case (rq.size)
                2'd0: ref_mem[a] = rq.data[7:0];
                2'd1: begin ref_mem[a] = rq.data[7:0]; ref_mem[a+1] = rq.data[15:8]; end
                2'd2: for (int k = 0; k < 4; k++) ref_mem[a+12'(k)] = rq.data[8*k +: 8];
                default: ref_tag[g] = rq.data[3:0];
            endcase
        end else begin
            lat = 3;
            case (rq.size)
                2'd0: begin b = ref_mem[a]; d = rq.uns ? {24'h0, b} : {{24{b[7]}}, b}; end
                2'd1: begin h = {ref_mem[a+1], ref_mem[a]}; d = rq.uns ? {16'h0, h} : {{16{h[15]}}, h}; end
                2'd2: d = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
                default: d = {28'h0, ref_tag[g]};
            endcase
            if (tf) d = '0;
        end
    endtask

    function automatic logic [3:0] exp_sel(input logic [1:0] size);
        case (size)
            2'd0: return 4'b0001;
            2'd1: return 4'b0011;
            2'd2: return 4'b1111;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic req_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic chk, input logic [31:0] addr, input logic [31:0] data);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.chk = chk; r.addr = addr; r.data = data;
        return r;
    endfunction

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic do_req(input req_t rq, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = rq.we;
        bus.req_size_i     = rq.size;
        bus.req_unsigned_i = rq.uns;
        bus.req_check_i    = rq.chk;
        bus.req_addr_i     = rq.addr;
        bus.req_data_i     = rq.data;
        for (int k = 0; k < 20 && !bus.req_ready_o; k++) @(negedge clk);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.req_ready_o) o.rdy_bad = 1'b1;
            if (bus.wb_cyc_o) begin
                o.cyc++;
                o.sel   = bus.wb_sel_o;
                o.addr  = bus.wb_addr_o;
                o.wdata = bus.wb_data_o;
                o.we    = bus.wb_we_o;
                if (bus.check_tags_o) o.chk = 1'b1;
            end
            if (bus.clear_mismatch_o) o.clr++;
            if (bus.resp_valid_o) begin
                o.lat  = k;
                o.data = bus.resp_data_o;
                o.mis  = bus.resp_misalign_o;
                o.be   = bus.resp_buserr_o;
                o.tf   = bus.resp_tagfault_o;
                break;
            end
        end
    endtask

    task automatic check_obs(input string nm, input req_t rq, input logic [31:0] ed, input logic emis,
                             input logic ebe, input logic etf, input int elat, input obs_t o);
        check({nm, ".lat"}, o.lat, elat);
        check({nm, ".data"}, o.data, ed);
        check({nm, ".misalign"}, {31'h0, o.mis}, {31'h0, emis});
        check({nm, ".buserr"}, {31'h0, o.be}, {31'h0, ebe});
        check({nm, ".tagfault"}, {31'h0, o.tf}, {31'h0, etf});
        check({nm, ".cyc_cycles"}, o.cyc, elat - 1);
        check({nm, ".clear_pulses"}, o.clr, (!emis && !ebe) ? 1 : 0);
        check({nm, ".ready_low"}, {31'h0, o.rdy_bad}, 32'h0);
        if (!emis) begin
            check({nm, ".sel"}, {28'h0, o.sel}, {28'h0, exp_sel(rq.size)});
            check({nm, ".addr"}, o.addr, rq.addr);
            check({nm, ".we"}, {31'h0, o.we}, {31'h0, rq.we});
            check({nm, ".check_tags"}, {31'h0, o.chk}, {31'h0, rq.chk && rq.size != 2'd3});
            if (rq.we) check({nm, ".wdata"}, o.wdata, rq.data);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vt[$];
        obs_t        o;
        req_t        rq;
        logic [31:0] ed;
        logic        emis, etf, bad;
        int          elat;

        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
        bus.req_unsigned_i = 1'b0; bus.req_check_i = 1'b0;
        bus.req_addr_i = '0; bus.req_data_i = '0;
        ram_noack = 1'b0; stale_mis = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("reset.ready", {31'h0, bus.req_ready_o}, 32'h1);
        check("reset.resp", {28'h0, bus.resp_valid_o, bus.resp_misalign_o, bus.resp_buserr_o, bus.resp_tagfault_o}, 32'h0);
        check("reset.wb", {26'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.check_tags_o, bus.clear_mismatch_o, |bus.wb_sel_o}, 32'h0);
        check("reset.addr", bus.wb_addr_o, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // {request, expected data, misalign, tagfault, latency}
        vt.push_back('{mk(1, 2, 0, 0, 32'h0000_0100, 32'h80FF_1234), 32'h0, 0, 0, 3});
        vt.push_back('{mk(1, 2, 0, 0, 32'h0000_0200, 32'h1122_3344), 32'h0, 0, 0, 3});
        vt.push_back('{mk(0, 0, 0, 0, 32'h0000_0103, 32'h0), 32'hFFFF_FF80, 0, 0, 3});
        vt.push_back('{mk(0, 0, 1, 0, 32'h0000_0103, 32'h0), 32'h0000_0080, 0, 0, 3});
        vt.push_back('{mk(0, 1, 0, 0, 32'h0000_0102, 32'h0), 32'hFFFF_80FF, 0, 0, 3});
        vt.push_back('{mk(0, 1, 1, 0, 32'h0000_0100, 32'h0), 32'h0000_1234, 0, 0, 3});
        vt.push_back('{mk(0, 0, 0, 0, 32'h0000_0100, 32'h0), 32'h0000_0034, 0, 0, 3});
        vt.push_back('{mk(0, 2, 0, 0, 32'h0000_0100, 32'h0), 32'h80FF_1234, 0, 0, 3});
        vt.push_back('{mk(1, 1, 0, 0, 32'h0000_0102, 32'hCAFE_BEEF), 32'h0, 0, 0, 4});
        vt.push_back('{mk(0, 2, 0, 0, 32'h0000_0100, 32'h0), 32'hBEEF_1234, 0, 0, 3});
        vt.push_back('{mk(0, 2, 0, 0, 32'h0000_0101, 32'h0), 32'h0, 1, 0, 1});
        vt.push_back('{mk(0, 1, 0, 0, 32'h0000_0101, 32'h0), 32'h0, 1, 0, 1});
        vt.push_back('{mk(1, 2, 0, 0, 32'h0000_0102, 32'h1), 32'h0, 1, 0, 1});
        vt.push_back('{mk(1, 0, 0, 0, 32'h0000_0101, 32'h0000_0055), 32'h0, 0, 0, 4});
        vt.push_back('{mk(0, 2, 0, 0, 32'h0000_0100, 32'h0), 32'hBEEF_5534, 0, 0, 3});
        vt.push_back('{mk(1, 3, 0, 0, 32'h0000_020C, 32'h0000_0005), 32'h0, 0, 0, 3});
        vt.push_back('{mk(0, 3, 0, 0, 32'h0000_0203, 32'h0), 32'h0000_0005, 0, 0, 3});
        vt.push_back('{mk(0, 2, 0, 1, 32'h3000_0200, 32'h0), 32'h0, 0, 1, 3});
        vt.push_back('{mk(0, 2, 0, 1, 32'h5000_0200, 32'h0), 32'h1122_3344, 0, 0, 3});
        vt.push_back('{mk(0, 2, 0, 0, 32'h3000_0200, 32'h0), 32'h1122_3344, 0, 0, 3});
        vt.push_back('{mk(1, 2, 0, 1, 32'h3000_0200, 32'h0000_0099), 32'h0, 0, 1, 3});
        vt.push_back('{mk(0, 2, 0, 1, 32'h5000_0200, 32'h0), 32'h0000_0099, 0, 0, 3});
        vt.push_back('{mk(0, 3, 0, 1, 32'hF000_0200, 32'h0), 32'h0000_0005, 0, 0, 3});

        foreach (vt[i]) begin
            ref_apply(vt[i].rq, ed, emis, etf, elat);
            do_req(vt[i].rq, o);
            check_obs($sformatf("vec%0d", i), vt[i].rq, vt[i].d, vt[i].mis, 1'b0, vt[i].tf, vt[i].lat, o);
        end

        // Stale mismatch flag while idle must not produce any response.
        stale_mis = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid_o || !bus.req_ready_o || bus.wb_cyc_o) bad = 1'b1;
        end
        stale_mis = 1'b0;
        check("stale_idle", {31'h0, bad}, 32'h0);
        rq = mk(0, 2, 0, 1, 32'h5000_0200, 32'h0);
        ref_apply(rq, ed, emis, etf, elat);
        do_req(rq, o);
        check_obs("after_stale", rq, ed, emis, 1'b0, etf, elat, o);

        // Slave never acknowledges.
        ram_noack = 1'b1;
        rq = mk(0, 2, 0, 0, 32'h0000_0100, 32'h0);
        do_req(rq, o);
        check_obs("timeout", rq, 32'h0, 1'b0, 1'b1, 1'b0, TMO, o);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_cyc_o || bus.wb_stb_o || bus.resp_valid_o) bad = 1'b1;
        end
        check("timeout.bus_idle_after", {31'h0, bad}, 32'h0);
        ram_noack = 1'b0;

        for (int i = 0; i < 80; i++) begin
            rq = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), {4'($urandom_range(0, 3)), 16'h0, 12'($urandom_range(0, 1023))},
                    $urandom);
            if (rq.size == 2'd3 && rq.we) rq.data = 32'($urandom_range(0, 3));
            ref_apply(rq, ed, emis, etf, elat);
            do_req(rq, o);
            check_obs($sformatf("rand%0d", i), rq, ed, emis, 1'b0, etf, elat, o);
        end

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
        bus.req_check_i = 1'b0; bus.req_addr_i = 32'h0000_0100;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid.cyc_before", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h3);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.cyc_dropped", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid_o || bus.wb_cyc_o) bad = 1'b1;
        end
        check("rst_mid.no_resp", {31'h0, bad}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_mid.ready_after", {31'h0, bus.req_ready_o}, 32'h1);
        rq = mk(0, 2, 0, 0, 32'h0000_0100, 32'h0);
        ref_apply(rq, ed, emis, etf, elat);
        do_req(rq, o);
        check_obs("rst_mid.recover", rq, ed, emis, 1'b0, etf, elat, o);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
